// File: rtl/ptmch_spi_gen.sv
// ptmch_spi_gen: SPI mode-0 initiator issuing opcode + 0..3 argument byte frames.
// Optional read phase (8 extra SCK periods, MISO capture) under `define PTMCH_SPI_RD_EN.
module ptmch_spi_gen #(
  parameter int P_CLK_DIV  = 8,
  parameter int P_CS_SETUP = 4,
  parameter int P_CS_HOLD  = 4,
  parameter int P_CS_IDLE  = 8
) (
  input  logic        RESET_N,
  input  logic        CLK160M,
  input  logic        START,
  input  logic [7:0]  INST,
  input  logic [23:0] ARG,
  input  logic [1:0]  ARG_LEN,
`ifdef PTMCH_SPI_RD_EN
  input  logic        RD_REQ,
  input  logic        SPI_MISO,
  output logic [7:0]  RD_DATA,
`endif
  output logic        BUSY,
  output logic        DONE,
  output logic        SPI_CS,
  output logic        SPI_CLK,
  output logic        SPI_MOSI
);

  localparam logic [7:0] DIV_M1   = 8'(P_CLK_DIV - 1);
  localparam logic [7:0] SETUP_M1 = 8'(P_CS_SETUP - 1);
  localparam logic [7:0] HOLD_M1  = 8'(P_CS_HOLD - 1);
  localparam logic [7:0] IDLE_M1  = 8'(P_CS_IDLE - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_HOLD,
    S_GAP
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] sr_q, sr_d;
  logic [5:0]  ntx_q, ntx_d;
  logic [5:0]  nbits_q, nbits_d;
  logic [5:0]  bit_q, bit_d;
  logic [7:0]  hcnt_q, hcnt_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        cs_q, cs_d;
  logic        sck_q, sck_d;
  logic        mosi_q, mosi_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [5:0]  tx_bits;
  logic [5:0]  rd_bits;

  assign tx_bits = 6'd8 + {1'b0, ARG_LEN, 3'b000};

`ifdef PTMCH_SPI_RD_EN
  logic       rd_q, rd_d;
  logic [7:0] rx_q, rx_d;
  logic [7:0] rdat_q, rdat_d;
  logic       miso_s1_q, miso_s2_q;

  assign rd_bits = RD_REQ ? 6'd8 : 6'd0;
  assign RD_DATA = rdat_q;
`else
  assign rd_bits = 6'd0;
`endif

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    ntx_d   = ntx_q;
    nbits_d = nbits_q;
    bit_d   = bit_q;
    hcnt_d  = hcnt_q;
    cnt_d   = cnt_q;
    cs_d    = cs_q;
    sck_d   = sck_q;
    mosi_d  = mosi_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef PTMCH_SPI_RD_EN
    rd_d    = rd_q;
    rx_d    = rx_q;
    rdat_d  = rdat_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (START) begin
          sr_d    = {INST, ARG};
          ntx_d   = tx_bits;
          nbits_d = tx_bits + rd_bits;
          cs_d    = 1'b0;
          busy_d  = 1'b1;
          mosi_d  = INST[7];
          cnt_d   = 8'd0;
          state_d = S_SETUP;
`ifdef PTMCH_SPI_RD_EN
          rd_d    = RD_REQ;
`endif
        end
      end
      S_SETUP: begin
        if (cnt_q == SETUP_M1) begin
          hcnt_d  = 8'd0;
          bit_d   = 6'd0;
          state_d = S_SHIFT;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_SHIFT: begin
        if (hcnt_q == DIV_M1) begin
          hcnt_d = 8'd0;
          if (!sck_q) begin
            sck_d = 1'b1;
            bit_d = bit_q + 6'd1;
          end else begin
            sck_d = 1'b0;
            if (bit_q == nbits_q) begin
              cnt_d   = 8'd0;
              state_d = S_HOLD;
            end else begin
              // read-phase periods drive zero on MOSI
              sr_d   = {sr_q[30:0], 1'b0};
              mosi_d = (bit_q >= ntx_q) ? 1'b0 : sr_q[30];
            end
          end
        end else begin
          hcnt_d = hcnt_q + 8'd1;
        end
`ifdef PTMCH_SPI_RD_EN
        if (sck_q && (hcnt_q == DIV_M1) && (bit_q > ntx_q))
          rx_d = {rx_q[6:0], miso_s2_q};
`endif
      end
      S_HOLD: begin
        if (cnt_q == HOLD_M1) begin
          cs_d    = 1'b1;
          mosi_d  = 1'b0;
          cnt_d   = 8'd0;
          state_d = S_GAP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_GAP: begin
        if (cnt_q == IDLE_M1) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
`ifdef PTMCH_SPI_RD_EN
          if (rd_q)
            rdat_d = rx_q;
`endif
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK160M or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= S_IDLE;
      sr_q    <= '0;
      ntx_q   <= '0;
      nbits_q <= '0;
      bit_q   <= '0;
      hcnt_q  <= '0;
      cnt_q   <= '0;
      cs_q    <= 1'b1;
      sck_q   <= 1'b0;
      mosi_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      ntx_q   <= ntx_d;
      nbits_q <= nbits_d;
      bit_q   <= bit_d;
      hcnt_q  <= hcnt_d;
      cnt_q   <= cnt_d;
      cs_q    <= cs_d;
      sck_q   <= sck_d;
      mosi_q  <= mosi_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

`ifdef PTMCH_SPI_RD_EN
  always_ff @(posedge CLK160M or negedge RESET_N) begin
    if (!RESET_N) begin
      rd_q      <= 1'b0;
      rx_q      <= '0;
      rdat_q    <= '0;
      miso_s1_q <= 1'b0;
      miso_s2_q <= 1'b0;
    end else begin
      rd_q      <= rd_d;
      rx_q      <= rx_d;
      rdat_q    <= rdat_d;
      miso_s1_q <= SPI_MISO;
      miso_s2_q <= miso_s1_q;
    end
  end
`endif

  assign BUSY     = busy_q;
  assign DONE     = done_q;
  assign SPI_CS   = cs_q;
  assign SPI_CLK  = sck_q;
  assign SPI_MOSI = mosi_q;

endmodule

// File: tb/tb_ptmch_spi_gen.sv
// tb_ptmch_spi_gen: directed frames with hand-computed timing and bit patterns.
// Read-phase scenario is compiled only with PTMCH_SPI_RD_EN defined.
module tb_ptmch_spi_gen;

  logic        CLK160M = 1'b0;
  logic        RESET_N = 1'b0;
  logic        START   = 1'b0;
  logic [7:0]  INST    = '0;
  logic [23:0] ARG     = '0;
  logic [1:0]  ARG_LEN = '0;
  logic        RD_REQ  = 1'b0;
  logic        BUSY, DONE, SPI_CS, SPI_CLK, SPI_MOSI;
`ifdef PTMCH_SPI_RD_EN
  logic        SPI_MISO = 1'b0;
  logic [7:0]  RD_DATA;
  logic [7:0]  miso_byte = 8'h00;
  int          falls = 0;
`endif

  ptmch_spi_gen dut (
    .RESET_N (RESET_N),
    .CLK160M (CLK160M),
    .START   (START),
    .INST    (INST),
    .ARG     (ARG),
    .ARG_LEN (ARG_LEN),
`ifdef PTMCH_SPI_RD_EN
    .RD_REQ  (RD_REQ),
    .SPI_MISO(SPI_MISO),
    .RD_DATA (RD_DATA),
`endif
    .BUSY    (BUSY),
    .DONE    (DONE),
    .SPI_CS  (SPI_CS),
    .SPI_CLK (SPI_CLK),
    .SPI_MOSI(SPI_MOSI)
  );

  always #5 CLK160M = ~CLK160M;

  int checks = 0;
  int errors = 0;

  logic        mon_clr = 1'b0;
  int          rel = 0, cs_low = 0, busy_cnt = 0, done_cnt = 0;
  int          done_rel = 0, rises = 0, bad_edge = 0, cs_fall_rel = 0;
  logic [39:0] shreg = '0;
  logic        prev_sck = 1'b0, prev_cs = 1'b1;
  logic [7:0]  rd_at_done = '0;

  // rel counts cycles since the START cycle (cycle 0)
  always @(negedge CLK160M) begin
    if (mon_clr) begin
      rel <= 1; cs_low <= 0; busy_cnt <= 0; done_cnt <= 0;
      done_rel <= 0; rises <= 0; bad_edge <= 0; cs_fall_rel <= 0;
      shreg <= '0;
    end else begin
      rel <= rel + 1;
      if (!SPI_CS) cs_low <= cs_low + 1;
      if (BUSY) busy_cnt <= busy_cnt + 1;
      if (DONE) begin
        done_cnt <= done_cnt + 1;
        done_rel <= rel;
      end
      if (SPI_CLK && !prev_sck) begin
        rises <= rises + 1;
        shreg <= {shreg[38:0], SPI_MOSI};
      end
      if (SPI_CS && SPI_CLK) bad_edge <= bad_edge + 1;
      if (prev_cs && !SPI_CS) cs_fall_rel <= rel;
    end
    prev_sck <= SPI_CLK;
    prev_cs  <= SPI_CS;
  end

`ifdef PTMCH_SPI_RD_EN
  // slave model: next bit driven after each SCK fall; read bits follow fall 8
  always @(negedge SPI_CLK or posedge SPI_CS) begin
    if (SPI_CS) begin
      falls    <= 0;
      SPI_MISO <= 1'b0;
    end else begin
      falls <= falls + 1;
      if (falls + 1 >= 8 && falls + 1 < 16)
        SPI_MISO <= miso_byte[7 - (falls + 1 - 8)];
      else
        SPI_MISO <= 1'b0;
    end
  end
`endif

  task automatic start_frame(input logic [7:0] i, input logic [23:0] a,
                             input logic [1:0] l, input logic rd);
    @(posedge CLK160M); #1;
    INST = i; ARG = a; ARG_LEN = l; RD_REQ = rd;
    START = 1'b1; mon_clr = 1'b1;
    @(posedge CLK160M); #1;
    START = 1'b0; mon_clr = 1'b0;
    INST = ~i; ARG = ~a; ARG_LEN = ~l; RD_REQ = ~rd;
  endtask

  task automatic wait_done(input string nm);
    bit seen = 1'b0;
    for (int k = 0; k < 1000; k++) begin
      @(negedge CLK160M);
      if (DONE === 1'b1) begin
        seen = 1'b1;
`ifdef PTMCH_SPI_RD_EN
        rd_at_done = RD_DATA;
`endif
        break;
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s_timeout: DONE not seen within 1000 cycles", nm);
    end
  endtask

  task automatic test_reset;
    RESET_N = 1'b0;
    repeat (3) @(posedge CLK160M);
    #1;
    checks++; if (SPI_CS !== 1'b1) begin errors++; $display("FAIL rst_cs: got %b want 1", SPI_CS); end
    checks++; if (SPI_CLK !== 1'b0) begin errors++; $display("FAIL rst_clk: got %b want 0", SPI_CLK); end
    checks++; if (SPI_MOSI !== 1'b0) begin errors++; $display("FAIL rst_mosi: got %b want 0", SPI_MOSI); end
    checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", BUSY); end
    checks++; if (DONE !== 1'b0) begin errors++; $display("FAIL rst_done: got %b want 0", DONE); end
`ifdef PTMCH_SPI_RD_EN
    checks++; if (RD_DATA !== 8'h00) begin errors++; $display("FAIL rst_rddata: got %h want 00", RD_DATA); end
`endif
    @(negedge CLK160M);
    RESET_N = 1'b1;
    repeat (2) @(posedge CLK160M);
  endtask

  // CS low 4+16*8+4=136, DONE at cycle 1+136+8=145, BUSY high cycles 1..144
  task automatic test_inst_only;
    start_frame(8'h0F, 24'h000000, 2'd0, 1'b0);
    wait_done("inst");
    repeat (3) @(posedge CLK160M);
    #1;
    checks++; if (rises !== 8) begin errors++; $display("FAIL inst_rises: got %0d want 8", rises); end
    checks++; if (shreg !== 40'h0F) begin errors++; $display("FAIL inst_bits: got %h want 0f", shreg); end
    checks++; if (cs_low !== 136) begin errors++; $display("FAIL inst_cslow: got %0d want 136", cs_low); end
    checks++; if (done_rel !== 145) begin errors++; $display("FAIL inst_done_cycle: got %0d want 145", done_rel); end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL inst_done_cnt: got %0d want 1", done_cnt); end
    checks++; if (busy_cnt !== 144) begin errors++; $display("FAIL inst_busy: got %0d want 144", busy_cnt); end
    checks++; if (cs_fall_rel !== 1) begin errors++; $display("FAIL inst_cs_fall: got %0d want 1", cs_fall_rel); end
    checks++; if (bad_edge !== 0) begin errors++; $display("FAIL inst_sck_cs_high: got %0d want 0", bad_edge); end
    checks++; if (SPI_MOSI !== 1'b0) begin errors++; $display("FAIL inst_mosi_idle: got %b want 0", SPI_MOSI); end
  endtask

  task automatic test_args;
    // one argument byte: CS low 4+256+4=264, DONE at 273
    start_frame(8'h1F, 24'hA05555, 2'd1, 1'b0);
    wait_done("arg1");
    repeat (3) @(posedge CLK160M);
    #1;
    checks++; if (rises !== 16) begin errors++; $display("FAIL arg1_rises: got %0d want 16", rises); end
    checks++; if (shreg !== 40'h1FA0) begin errors++; $display("FAIL arg1_bits: got %h want 1fa0", shreg); end
    checks++; if (cs_low !== 264) begin errors++; $display("FAIL arg1_cslow: got %0d want 264", cs_low); end
    checks++; if (done_rel !== 273) begin errors++; $display("FAIL arg1_done_cycle: got %0d want 273", done_rel); end
    // two argument bytes: CS low 4+384+4=392, DONE at 401
    start_frame(8'h13, 24'hABCDEF, 2'd2, 1'b0);
    wait_done("arg2");
    repeat (3) @(posedge CLK160M);
    #1;
    checks++; if (rises !== 24) begin errors++; $display("FAIL arg2_rises: got %0d want 24", rises); end
    checks++; if (shreg !== 40'h13ABCD) begin errors++; $display("FAIL arg2_bits: got %h want 13abcd", shreg); end
    checks++; if (cs_low !== 392) begin errors++; $display("FAIL arg2_cslow: got %0d want 392", cs_low); end
    checks++; if (done_rel !== 401) begin errors++; $display("FAIL arg2_done_cycle: got %0d want 401", done_rel); end
    // three argument bytes: CS low 4+512+4=520, DONE at 529
    start_frame(8'hD8, 24'h123456, 2'd3, 1'b0);
    wait_done("arg3");
    repeat (3) @(posedge CLK160M);
    #1;
    checks++; if (rises !== 32) begin errors++; $display("FAIL arg3_rises: got %0d want 32", rises); end
    checks++; if (shreg !== 40'hD8123456) begin errors++; $display("FAIL arg3_bits: got %h want d8123456", shreg); end
    checks++; if (cs_low !== 520) begin errors++; $display("FAIL arg3_cslow: got %0d want 520", cs_low); end
    checks++; if (done_rel !== 529) begin errors++; $display("FAIL arg3_done_cycle: got %0d want 529", done_rel); end
    checks++; if (bad_edge !== 0) begin errors++; $display("FAIL arg3_sck_cs_high: got %0d want 0", bad_edge); end
    checks++; if (SPI_CLK !== 1'b0) begin errors++; $display("FAIL arg3_sck_idle: got %b want 0", SPI_CLK); end
  endtask

  task automatic test_start_ignored;
    start_frame(8'h0F, 24'h000000, 2'd0, 1'b0);
    repeat (9) @(posedge CLK160M);
    #1; START = 1'b1; INST = 8'hFF; ARG_LEN = 2'd3;
    @(posedge CLK160M); #1; START = 1'b0;
    repeat (89) @(posedge CLK160M);
    #1; START = 1'b1;
    @(posedge CLK160M); #1; START = 1'b0;
    wait_done("ign");
    repeat (200) @(posedge CLK160M);
    #1;
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL ign_done_cnt: got %0d want 1", done_cnt); end
    checks++; if (rises !== 8) begin errors++; $display("FAIL ign_rises: got %0d want 8", rises); end
    checks++; if (shreg !== 40'h0F) begin errors++; $display("FAIL ign_bits: got %h want 0f", shreg); end
    checks++; if (done_rel !== 145) begin errors++; $display("FAIL ign_done_cycle: got %0d want 145", done_rel); end
    checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL ign_busy_after: got %b want 0", BUSY); end
  endtask

  task automatic test_back_to_back;
    start_frame(8'h0F, 24'h000000, 2'd0, 1'b0);
    wait_done("b2b_first");
    start_frame(8'hA5, 24'h000000, 2'd0, 1'b0);
    wait_done("b2b_second");
    repeat (3) @(posedge CLK160M);
    #1;
    checks++; if (cs_fall_rel !== 1) begin errors++; $display("FAIL b2b_cs_fall: got %0d want 1", cs_fall_rel); end
    checks++; if (done_rel !== 145) begin errors++; $display("FAIL b2b_done_cycle: got %0d want 145", done_rel); end
    checks++; if (shreg !== 40'hA5) begin errors++; $display("FAIL b2b_bits: got %h want a5", shreg); end
  endtask

  task automatic test_reset_mid;
    int   r = 0;
    int   nd = 0;
    logic ps;
    start_frame(8'hD8, 24'h123456, 2'd3, 1'b0);
    ps = SPI_CLK;
    for (int k = 0; k < 2000 && r < 5; k++) begin
      @(negedge CLK160M);
      if (SPI_CLK && !ps) r++;
      ps = SPI_CLK;
    end
    RESET_N = 1'b0;
    #1;
    checks++; if (r !== 5) begin errors++; $display("FAIL mid_rise_seen: got %0d want 5", r); end
    checks++; if (SPI_CS !== 1'b1) begin errors++; $display("FAIL mid_cs: got %b want 1", SPI_CS); end
    checks++; if (SPI_CLK !== 1'b0) begin errors++; $display("FAIL mid_clk: got %b want 0", SPI_CLK); end
    checks++; if (SPI_MOSI !== 1'b0) begin errors++; $display("FAIL mid_mosi: got %b want 0", SPI_MOSI); end
    checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b want 0", BUSY); end
    repeat (3) @(posedge CLK160M);
    @(negedge CLK160M);
    RESET_N = 1'b1;
    for (int k = 0; k < 600; k++) begin
      @(negedge CLK160M);
      if (DONE === 1'b1) nd++;
    end
    checks++; if (nd !== 0) begin errors++; $display("FAIL mid_no_done: got %0d want 0", nd); end
    start_frame(8'h0F, 24'h000000, 2'd0, 1'b0);
    wait_done("mid_clean");
    repeat (3) @(posedge CLK160M);
    #1;
    checks++; if (rises !== 8) begin errors++; $display("FAIL mid_clean_rises: got %0d want 8", rises); end
    checks++; if (shreg !== 40'h0F) begin errors++; $display("FAIL mid_clean_bits: got %h want 0f", shreg); end
    checks++; if (cs_low !== 136) begin errors++; $display("FAIL mid_clean_cslow: got %0d want 136", cs_low); end
    checks++; if (done_rel !== 145) begin errors++; $display("FAIL mid_clean_done: got %0d want 145", done_rel); end
  endtask

`ifdef PTMCH_SPI_RD_EN
  task automatic test_read;
    miso_byte = 8'h5A;
    start_frame(8'h0F, 24'h000000, 2'd0, 1'b1);
    wait_done("rd");
    repeat (3) @(posedge CLK160M);
    #1;
    checks++; if (rises !== 16) begin errors++; $display("FAIL rd_rises: got %0d want 16", rises); end
    checks++; if (shreg !== 40'h0F00) begin errors++; $display("FAIL rd_mosi_bits: got %h want 0f00", shreg); end
    checks++; if (cs_low !== 264) begin errors++; $display("FAIL rd_cslow: got %0d want 264", cs_low); end
    checks++; if (rd_at_done !== 8'h5A) begin errors++; $display("FAIL rd_data_at_done: got %h want 5a", rd_at_done); end
    miso_byte = 8'hC3;
    start_frame(8'h0F, 24'h000000, 2'd0, 1'b0);
    wait_done("nord");
    repeat (3) @(posedge CLK160M);
    #1;
    checks++; if (rises !== 8) begin errors++; $display("FAIL nord_rises: got %0d want 8", rises); end
    checks++; if (done_rel !== 145) begin errors++; $display("FAIL nord_done: got %0d want 145", done_rel); end
    checks++; if (RD_DATA !== 8'h5A) begin errors++; $display("FAIL nord_rddata: got %h want 5a", RD_DATA); end
  endtask
`endif

  initial begin
    test_reset;
    test_inst_only;
    test_args;
    test_start_ignored;
    test_back_to_back;
    test_reset_mid;
`ifdef PTMCH_SPI_RD_EN
    test_read;
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
